// File: rtl/serial_subtractor_if.sv
// Bus bundle for serial_subtractor: start/operands in, status and result out.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (output start, a, b, input busy, done, diff, borrow_out);
  modport slave  (input start, a, b, output busy, done, diff, borrow_out);
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor a-b, LSB first, one bit per cycle.
// Define SERSUB_SAT_EN to clamp underflowed results to zero.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_subtractor_if.slave bus
);
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic [CNT_W-1:0] cnt;
  logic             br;
  logic             a0, b0, d, br_nx, last, accept;
  logic [WIDTH-1:0] res_nx, diff_nx;
  logic             busy_nx, done_nx, borrow_nx;

  // One-bit full-subtractor slice and control decodes
  always_comb begin
    a0     = a_sh[0];
    b0     = b_sh[0];
    d      = a0 ^ b0 ^ br;
    br_nx  = (~a0 & b0) | (~(a0 ^ b0) & br);
    res_nx = WIDTH'({d, res_sh} >> 1);
    last   = (state == RUN) && (cnt == LAST);
    accept = (state != RUN) && bus.start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    state_nx = bus.start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values for the registered outputs
  always_comb begin
    busy_nx   = (state_nx == RUN);
    done_nx   = (state_nx == DONE);
    diff_nx   = bus.diff;
    borrow_nx = bus.borrow_out;
    if (last) begin
      borrow_nx = br_nx;
`ifdef SERSUB_SAT_EN
      diff_nx   = br_nx ? '0 : res_nx;
`else
      diff_nx   = res_nx;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.diff       <= '0;
      bus.borrow_out <= 1'b0;
    end else begin
      bus.busy       <= busy_nx;
      bus.done       <= done_nx;
      bus.diff       <= diff_nx;
      bus.borrow_out <= borrow_nx;
    end
  end

  // Operand shift registers, partial result, borrow and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      br     <= 1'b0;
    end else if (accept) begin
      a_sh   <= bus.a;
      b_sh   <= bus.b;
      res_sh <= '0;
      cnt    <= '0;
      br     <= 1'b0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_nx;
      cnt    <= cnt + CNT_W'(1);
      br     <= br_nx;
    end
  end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 1..32).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction a-b.
REQ-005 The block SHALL have port a, input, WIDTH bits: minuend, sampled only when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits: subtrahend, sampled only when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit: high while the block is processing bits.
REQ-008 The block SHALL have port done, output, 1 bit: single-cycle pulse marking that the result is valid.
REQ-009 The block SHALL have port diff, output, WIDTH bits: registered difference, held until the next result.
REQ-010 The block SHALL have port borrow_out, output, 1 bit: final borrow, i.e. a<b unsigned, held with diff.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-012 IDLE with start=1 SHALL load the a/b shift registers, clear the borrow flop, clear the bit counter, and move to RUN.
REQ-013 IDLE with start=0 SHALL stay in IDLE.
REQ-014 Each RUN cycle SHALL process one bit, LSB first: d = a0^b0^br; br_next = (~a0&b0) | (~(a0^b0)&br).
REQ-015 d SHALL shift into the MSB of the result register; a and b SHALL shift right; the counter SHALL increment.
REQ-016 RUN SHALL move to DONE on the edge that processes bit WIDTH-1.
REQ-017 On that edge, diff SHALL load the full result and borrow_out SHALL load br_next.
REQ-018 Latency: start sampled at edge N gives done high in the cycle following edge N+WIDTH.
REQ-019 done SHALL be high only in DONE; busy SHALL be high only in RUN.
REQ-020 DONE with start=1 SHALL accept the new operands as in IDLE (back-to-back), with done still high that cycle.
REQ-021 DONE with start=0 SHALL go to IDLE.
REQ-022 start while in RUN SHALL be ignored; operand changes during RUN SHALL NOT affect the result.
REQ-023 The arithmetic SHALL be unsigned modulo 2^WIDTH: diff = (a-b) mod 2^WIDTH; borrow_out=1 iff a<b.
REQ-024 WIDTH=1 SHALL reproduce the half-subtractor truth table: diff=a^b, borrow_out=~a&b.

Reset
REQ-025 rst_n low SHALL immediately force: state IDLE, busy=0, done=0, diff=0, borrow_out=0, counter=0, borrow flop=0.
REQ-026 Reset during RUN SHALL abandon the operation with no done pulse.
REQ-027 After rst_n deasserts, the first start SHALL be accepted on the first rising edge on which it is high.

Configuration
REQ-028 The macro SERSUB_SAT_EN SHALL control zero-saturation of underflowed results.
REQ-029 With SERSUB_SAT_EN defined, any result with a final borrow of 1 SHALL load diff=0; borrow_out SHALL still be 1.
REQ-030 Without SERSUB_SAT_EN, diff SHALL be the modulo result per REQ-023.
REQ-031 Timing and handshake SHALL be identical with and without SERSUB_SAT_EN.

Verification (WIDTH=8)
REQ-032 a=0x5A, b=0x3C, start pulse -> busy high 8 cycles, then done one cycle; diff=0x1E, borrow_out=0.
REQ-033 a=0x10, b=0x20 -> diff=0xF0, borrow_out=1; with SERSUB_SAT_EN, diff=0x00, borrow_out=1.
REQ-034 a=0xFF, b=0xFF, then a=0x00, b=0x01 started in the DONE cycle -> first result 0x00/0; second result 0xFF/1 eight cycles later, with no IDLE gap.
REQ-035 Start a=0x80, b=0x01, then pulse start with a=0x00, b=0xFF at cycle 3 of RUN -> second start ignored; result 0x7F/0.
REQ-036 Assert rst_n low at cycle 4 of RUN -> all outputs 0 immediately, no done pulse; the next start with a=0x03, b=0x02 -> diff=0x01, borrow_out=0.
REQ-037 WIDTH=1, all four a/b combinations -> diff/borrow_out = 0/0, 1/1, 1/0, 0/0 for ab=00, 01, 10, 11.
